stack_mem_port: RTL and testbench

STACK_MEM_PORT -- requirements
Module: stack_mem_port

---
 rtl/stack_mem_port_pkg.sv | 24 ++
 rtl/stack_ram.sv | 30 +++
 rtl/stack_mem_port.sv | 146 ++++++++++++++
 tb/tb_stack_mem_port.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_mem_port_pkg.sv
// Shared definitions for the stack memory port.
// Holds the SP-unit request op codes, the FSM state enumeration and the
// default stack top word address.
package stack_mem_port_pkg;

  // Op codes as driven by the SP unit; the remaining codes are no-ops
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  // Highest stack word address of the default 4096-word stack
  localparam int unsigned STACK_TOP = 4095;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO,
    POP_LO,
    POP_HI,
    POP_CAP,
    RESP
  } state_e;

endpackage

// File: rtl/stack_ram.sv
// DEPTH x 16 stack storage with one synchronous write port and one
// synchronous read port (1-cycle latency). Contents are never cleared.
// Ports: clk; we/waddr/wdata write port; re/raddr read request;
//        rdata read data, valid the cycle after re and held otherwise.
module stack_ram #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 4096
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // Write and read on the same edge; a read returns the pre-write contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/stack_mem_port.sv
// Stack memory port: moves 32-bit push/pop requests from the SP unit into
// a 16-bit-wide stack RAM as two word accesses. A push at A writes the high
// half to word A and the low half to A-1; a pop at A reads the low half from
// word A and the high half from A+1. Requests whose word pair would leave
// the RAM are rejected with err.
// Ports: clk, rst (sync, active high); req_valid/req_ready/req_op/req_addr/
//        push_data request side; pop_data last popped value; done one-cycle
//        completion pulse; err (with done) request was rejected.
module stack_mem_port
  import stack_mem_port_pkg::*;
#(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = STACK_TOP + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] push_data,
  output logic [31:0] pop_data,
  output logic        done,
  output logic        err
);

  localparam int unsigned POP_MAX = DEPTH - 2;

  state_e        state, state_next;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic [15:0]   lo_q;

  logic          accept;
  logic          push_ok;
  logic          pop_ok;
  logic [AW-1:0] req_word;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [15:0]   ram_wdata;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [15:0]   ram_rdata;
  logic          addr_unused;

  assign addr_unused = ^req_addr[31:AW];
  assign req_word    = req_addr[AW-1:0];
  assign accept      = req_valid && req_ready && (req_op == OP_PUSH || req_op == OP_POP);

  // Range checks keep A-1 and A+1 inside the RAM, so no wrap-around occurs
  assign push_ok = (req_word != '0);
  assign pop_ok  = (32'(req_word) <= POP_MAX);

  // Next state and RAM port control
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_waddr  = addr_q;
    ram_wdata  = data_q[31:16];
    ram_re     = 1'b0;
    ram_raddr  = addr_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_op == OP_PUSH) begin
            state_next = push_ok ? PUSH_HI : RESP;
          end else begin
            state_next = pop_ok ? POP_LO : RESP;
          end
        end
      end
      PUSH_HI: begin
        ram_we     = 1'b1;
        state_next = PUSH_LO;
      end
      PUSH_LO: begin
        ram_we     = 1'b1;
        ram_waddr  = addr_q - AW'(1);
        ram_wdata  = data_q[15:0];
        state_next = RESP;
      end
      POP_LO: begin
        ram_re     = 1'b1;
        state_next = POP_HI;
      end
      POP_HI: begin
        ram_re     = 1'b1;
        ram_raddr  = addr_q + AW'(1);
        state_next = POP_CAP;
      end
      POP_CAP: state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Reset shares the edge with the RAM, so it must also squash the access
    if (rst) begin
      state_next = IDLE;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
    end
  end

  // State register, request latches and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      lo_q      <= '0;
      pop_data  <= '0;
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == IDLE);
      done      <= (state_next == RESP);
      // Only rejected requests go straight from IDLE to RESP
      err       <= (state == IDLE) && (state_next == RESP);
      if (accept) begin
        addr_q <= req_word;
        data_q <= push_data;
      end
      if (state == POP_HI) begin
        lo_q <= ram_rdata;
      end
      if (state == POP_CAP) begin
        pop_data <= {ram_rdata, lo_q};
      end
    end
  end

  stack_ram #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_stack_mem_port.sv
// Directed bench for stack_mem_port: reset state, push/pop latency and data,
// boundary rejections, no-op and busy-time requests, reset mid-push, and
// random push/pop pairs.
module tb_stack_mem_port;
  import stack_mem_port_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = OP_NOP;
  logic [31:0] req_addr = '0;
  logic [31:0] push_data = '0;
  logic [31:0] pop_data;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  stack_mem_port dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .push_data (push_data),
    .pop_data  (pop_data),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Present one request, then count edges from acceptance until done is seen
  task automatic do_req(input logic [1:0] op, input int unsigned addr,
                        input logic [31:0] data, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    push_data = data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_addr  = '0;
    push_data = '0;
    lat = 1;
    @(negedge clk);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    tests++;
    if (pop_data !== 32'h0) begin fails++; $display("FAIL reset_pop_data got %h want 0", pop_data); end
  endtask

  task automatic test_push_pop();
    int lat;
    do_req(OP_PUSH, 4095, 32'hDEAD_BEEF, lat);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL push_top_lat got %0d want 3", lat); end
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL push_top_err got %b want 0", err); end
    do_req(OP_POP, 4094, 32'h0, lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL pop_top_lat got %0d want 4", lat); end
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL pop_top_err got %b want 0", err); end
    tests++;
    if (pop_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL pop_top_data got %h want deadbeef", pop_data); end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL done_pulse got done=%b ready=%b want done=0 ready=1", done, req_ready);
    end
    do_req(OP_PUSH, 1, 32'h1111_2222, lat);
    tests++;
    if (lat !== 3 || err !== 1'b0) begin fails++; $display("FAIL push_a1 got lat=%0d err=%b want lat=3 err=0", lat, err); end
  endtask

  task automatic test_reject();
    int lat;
    do_req(OP_PUSH, 0, 32'hFFFF_FFFF, lat);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL push_a0_lat got %0d want 1", lat); end
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL push_a0_err got %b want 1", err); end
    do_req(OP_POP, 0, 32'h0, lat);
    tests++;
    if (lat !== 4 || err !== 1'b0) begin fails++; $display("FAIL pop_a0 got lat=%0d err=%b want lat=4 err=0", lat, err); end
    tests++;
    if (pop_data !== 32'h1111_2222) begin fails++; $display("FAIL ram_unchanged got %h want 11112222", pop_data); end
    do_req(OP_POP, 4095, 32'h0, lat);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL pop_4095_lat got %0d want 1", lat); end
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL pop_4095_err got %b want 1", err); end
    tests++;
    if (pop_data !== 32'h1111_2222) begin fails++; $display("FAIL pop_4095_hold got %h want 11112222", pop_data); end
    @(negedge clk);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_after_resp got %b want 0", err); end
    do_req(OP_POP, 4094, 32'h0, lat);
    tests++;
    if (pop_data !== 32'hDEAD_BEEF || err !== 1'b0) begin
      fails++; $display("FAIL pop_4094_again got %h err=%b want deadbeef err=0", pop_data, err);
    end
  endtask

  task automatic test_nop();
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_addr  = 32'd50;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
        fails++; $display("FAIL nop11_%0d got ready=%b done=%b err=%b want 1 0 0", i, req_ready, done, err);
      end
    end
    req_op = OP_NOP;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1 || done !== 1'b0) begin
        fails++; $display("FAIL nop00_%0d got ready=%b done=%b want 1 0", i, req_ready, done);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_busy();
    int lat;
    int cyc;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_PUSH;
    req_addr  = 32'd200;
    push_data = 32'h5555_6666;
    @(posedge clk);
    #1;
    // A pop presented while busy must be ignored
    req_op    = OP_POP;
    req_addr  = 32'd1;
    push_data = 32'h0;
    cyc = 1;
    @(negedge clk);
    while (!done && cyc < 20) begin
      tests++;
      if (req_ready !== 1'b0) begin fails++; $display("FAIL busy_ready_%0d got %b want 0", cyc, req_ready); end
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc !== 3) begin fails++; $display("FAIL busy_push_lat got %0d want 3", cyc); end
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL resp_ready got %b want 0", req_ready); end
    req_valid = 1'b0;
    req_op    = OP_NOP;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
        fails++; $display("FAIL busy_ignored_%0d got done=%b ready=%b want 0 1", i, done, req_ready);
      end
    end
    tests++;
    if (pop_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL busy_pop_hold got %h want deadbeef", pop_data); end
    do_req(OP_POP, 199, 32'h0, lat);
    tests++;
    if (lat !== 4 || pop_data !== 32'h5555_6666) begin
      fails++; $display("FAIL busy_pop_back got lat=%0d data=%h want 4 55556666", lat, pop_data);
    end
  endtask

  task automatic test_reset_mid_push();
    int lat;
    do_req(OP_PUSH, 100, 32'hAAAA_BBBB, lat);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL prefill_lat got %0d want 3", lat); end
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_PUSH;
    req_addr  = 32'd100;
    push_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    @(posedge clk);
    // Now in PUSH_LO; the next edge resets
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL rst_mid_state got ready=%b done=%b err=%b want 1 0 0", req_ready, done, err);
    end
    tests++;
    if (pop_data !== 32'h0) begin fails++; $display("FAIL rst_mid_pop_data got %h want 0", pop_data); end
    do_req(OP_POP, 99, 32'h0, lat);
    tests++;
    if (pop_data !== 32'h1234_BBBB) begin fails++; $display("FAIL rst_mid_words got %h want 1234bbbb", pop_data); end
  endtask

  task automatic test_random_pairs();
    int lat;
    int unsigned addr;
    logic [31:0] data;
    for (int i = 0; i < 10; i++) begin
      addr = $urandom_range(4094, 1);
      data = $urandom;
      do_req(OP_PUSH, addr, data, lat);
      tests++;
      if (lat !== 3 || err !== 1'b0) begin
        fails++; $display("FAIL rnd_push_%0d got lat=%0d err=%b want 3 0", i, lat, err);
      end
      do_req(OP_POP, addr - 1, 32'h0, lat);
      tests++;
      if (lat !== 4 || err !== 1'b0 || pop_data !== data) begin
        fails++; $display("FAIL rnd_pop_%0d addr=%0d got lat=%0d err=%b data=%h want 4 0 %h",
                          i, addr - 1, lat, err, pop_data, data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_reject();
    test_nop();
    test_busy();
    test_reset_mid_push();
    test_random_pairs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
